timer_multi: RTL

- Parametrised multi-channel successor to the single-channel `timer`.
- NUM_CH independent counters, each with its own prescaler, compare value, periodic or one-shot mode, and interrupt enable.
- A shared write-1-to-clear pending register.
- Sits on the same simple peripheral bus (data_i/addr_i/we_i/data_o). Per-channel interrupts feed the core's `int_i` bus; the OR of all channels is also provided.

---
 rtl/timer_multi.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/timer_multi.sv
// timer_multi: NUM_CH independent prescaled counters with compare match,
// periodic or one-shot mode, per-channel interrupt enable and a shared
// write-1-to-clear pending register, on a simple peripheral bus.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   data_i     write data (32)
//   addr_i     byte address; only addr_i[7:0] is decoded
//   we_i       write strobe, one write per asserted cycle
//   data_o     read data, combinational from addr_i (32)
//   int_sig_o  per-channel interrupt = pending & IE (NUM_CH)
//   int_any_o  OR of int_sig_o
//
// Map: channel n at n*0x10 (+0x0 CTRL, +0x4 COUNT, +0x8 CMP), STATUS at 0xF0.
// CTRL: [0] EN, [1] MODE (1 = one-shot), [2] IE, [15:8] PRESC.
module timer_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned PRESC_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       data_i,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    output logic [31:0]       data_o,
    output logic [NUM_CH-1:0] int_sig_o,
    output logic              int_any_o
);

    localparam int unsigned CH_IDX_W   = 4;
    localparam int unsigned OFF_W      = 4;
    localparam logic [7:0]  STATUS_ADR = 8'hF0;
    localparam logic [3:0]  OFF_CTRL   = 4'h0;
    localparam logic [3:0]  OFF_COUNT  = 4'h4;
    localparam logic [3:0]  OFF_CMP    = 4'h8;

    // Per-channel state
    logic [NUM_CH-1:0]      r_en;
    logic [NUM_CH-1:0]      r_mode;
    logic [NUM_CH-1:0]      r_ie;
    logic [NUM_CH-1:0]      r_pend;
    logic [PRESC_WIDTH-1:0] r_presc [NUM_CH];
    logic [PRESC_WIDTH-1:0] r_psc   [NUM_CH];
    logic [CNT_WIDTH-1:0]   r_count [NUM_CH];
    logic [CNT_WIDTH-1:0]   r_cmp   [NUM_CH];

    // Decoded strobes and per-channel events
    logic [CH_IDX_W-1:0]    w_ch;
    logic [OFF_W-1:0]       w_off;
    logic [NUM_CH-1:0]      w_tick;
    logic [NUM_CH-1:0]      w_match;
    logic [NUM_CH-1:0]      w_wr_ctrl;
    logic [NUM_CH-1:0]      w_wr_count;
    logic [NUM_CH-1:0]      w_wr_cmp;
    logic [NUM_CH-1:0]      w_clr;
    logic                   w_wr_status;
    logic [31:0]            w_rdata;
    logic                   w_unused;

    assign w_ch  = addr_i[7:4];
    assign w_off = addr_i[3:0];

    // Bits not decoded (and data bits beyond a narrow CNT_WIDTH) are intentionally dropped
    assign w_unused = ^{addr_i[31:8], data_i};

    // Address decode and tick/match generation
    always_comb begin
        w_tick      = '0;
        w_match     = '0;
        w_wr_ctrl   = '0;
        w_wr_count  = '0;
        w_wr_cmp    = '0;
        w_wr_status = we_i && (addr_i[7:0] == STATUS_ADR);
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            w_tick[n]  = r_en[n] && (r_psc[n] == r_presc[n]);
            w_match[n] = w_tick[n] && (r_count[n] == r_cmp[n]);
            if (we_i && (w_ch == CH_IDX_W'(n))) begin
                w_wr_ctrl[n]  = (w_off == OFF_CTRL);
                w_wr_count[n] = (w_off == OFF_COUNT);
                w_wr_cmp[n]   = (w_off == OFF_CMP);
            end
        end
        w_clr = w_wr_status ? data_i[NUM_CH-1:0] : '0;
    end

    // Channel state update; software writes take priority over hardware
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en   <= '0;
            r_mode <= '0;
            r_ie   <= '0;
            r_pend <= '0;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                r_presc[n] <= '0;
                r_psc[n]   <= '0;
                r_count[n] <= '0;
                r_cmp[n]   <= '0;
            end
        end else begin
            // A hardware set beats a W1C of the same bit
            r_pend <= (r_pend & ~w_clr) | w_match;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (w_wr_ctrl[n] || w_wr_count[n] || !r_en[n] || w_tick[n]) begin
                    r_psc[n] <= '0;
                end else begin
                    r_psc[n] <= r_psc[n] + PRESC_WIDTH'(1);
                end

                if (w_wr_count[n]) begin
                    r_count[n] <= data_i[CNT_WIDTH-1:0];
                end else if (w_match[n]) begin
                    r_count[n] <= '0;
                end else if (w_tick[n]) begin
                    r_count[n] <= r_count[n] + CNT_WIDTH'(1);
                end

                if (w_wr_ctrl[n]) begin
                    r_en[n]    <= data_i[0];
                    r_mode[n]  <= data_i[1];
                    r_ie[n]    <= data_i[2];
                    r_presc[n] <= data_i[8 +: PRESC_WIDTH];
                end else if (w_match[n] && r_mode[n]) begin
                    r_en[n] <= 1'b0;
                end

                if (w_wr_cmp[n]) begin
                    r_cmp[n] <= data_i[CNT_WIDTH-1:0];
                end
            end
        end
    end

    // Read mux; unmapped offsets and absent channels read 0
    always_comb begin
        w_rdata = '0;
        if (addr_i[7:0] == STATUS_ADR) begin
            w_rdata = 32'(r_pend);
        end
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (w_ch == CH_IDX_W'(n)) begin
                case (w_off)
                    OFF_CTRL:  w_rdata = {16'h0, 8'(r_presc[n]), 5'h0, r_ie[n], r_mode[n], r_en[n]};
                    OFF_COUNT: w_rdata = 32'(r_count[n]);
                    OFF_CMP:   w_rdata = 32'(r_cmp[n]);
                    default:   w_rdata = '0;
                endcase
            end
        end
    end

    assign data_o    = w_rdata;
    assign int_sig_o = r_pend & r_ie;
    assign int_any_o = |int_sig_o;

endmodule
